cr16_decode_ctrl: RTL
=====================

// Module: cr16_decode_ctrl
// PURPOSE
//  Instruction-side counterpart of the ALU: accepts 16-bit instruction words, decodes them into
//  the 8-bit ALU opcode, register addresses and immediate, sequences a multi-cycle execute, and
//  consumes the ALU's 5-bit flag output into the processor status register (PSR).
//  Sits between instruction fetch, the register file (sync read) and the ALU.
// PARAMETERS
//  DATA_W     16      datapath width (ALU A/B/C, register file data)
//  FLAG_W     5       flag width; bit map C=4 L=3 F=2 Z=1 N=0
//  PSR_RST    5'b0    PSR value on reset
// PORTS
//  clk          in   1       clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  instr_valid  in   1       instruction word present
//  instr        in   16      [15:12] op, [11:8] Rdest, [7:4] ext/ImmHi, [3:0] Rsrc/ImmLo
//  instr_ready  out  1       controller can accept (IDLE only)
//  rf_addr_a    out  4       RF read port A = Rdest (ALU A)
//  rf_addr_b    out  4       RF read port B = Rsrc (ALU B when b_sel=0)
//  b_sel        out  1       1: ALU B = imm, 0: ALU B = RF port B
//  imm          out  16      {8'h00, instr[7:0]} (ALU does its own sign extension)
//  alu_opcode   out  8       {instr[15:12], instr[7:4]}
//  alu_c        in   16      ALU result
//  alu_flags    in   5       ALU flags
//  rf_we        out  1       RF write strobe, 1 cycle
//  rf_waddr     out  4       RF write address (Rdest)
//  rf_wdata     out  16      RF write data (registered alu_c)
//  psr          out  5       status register
//  illegal      out  1       1-cycle pulse: decoded word not legal
//  trap         out  1       sticky trap (only with ILLEGAL_TRAP_EN)
//  trap_clr     in   1       clears trap (ignored without ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  Reset: state=IDLE, instr_ready=1, rf_we=0, illegal=0, trap=0, psr=PSR_RST, all other regs 0.
//  FSM IDLE->DECODE->EXEC->WB->IDLE; accept on instr_valid&instr_ready in IDLE, instr latched.
//   DECODE: rf_addr_a/b, b_sel, imm, alu_opcode driven from latched word; RF read launched.
//   EXEC: ALU operands stable; alu_c and alu_flags registered at end of cycle.
//   WB: rf_we=1 (unless suppressed), rf_wdata=registered alu_c; psr updated at end of WB.
//  Latency: accept edge = cycle 0, rf_we high in cycle 3; throughput 1 instruction / 4 cycles.
//  instr_valid outside IDLE ignored; no word is buffered. Decode outputs hold from DECODE to WB.
//  Legal set: op 0000 ext {1,2,3,5,6,9,B,D}; op {1,2,3,5,9,B,D,F} (b_sel=1); op 1000 ext
//   {0,1,2,3,4,6} (ext 000x/001x are immediate shifts, b_sel=1; 0100/0110 b_sel=0).
//   All else (incl. 0100 LOAD/STOR/JAL/Jcond, 1100 Bcond) illegal.
//  Illegal: illegal pulses in DECODE cycle, FSM goes DECODE->IDLE, no rf_we, psr unchanged.
//  PSR update (all 5 bits <- registered flags): ADD, ADDI, SUB, SUBI, CMP, CMPI, AND, ANDI.
//   All other legal ops leave psr unchanged.
//  Write-back suppressed for CMP (0000/1011) and CMPI (1011); those still update psr.
//  Reset asserted mid-instruction: immediate return to reset values; in-flight word dropped,
//   no partial rf_we or psr write.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal also sets trap; while trap=1 instr_ready=0 and FSM holds
//   IDLE; trap_clr=1 clears trap next edge; illegal and trap_clr in same cycle -> trap=1.
//  Undefined: illegal words act as NOPs (pulse only); trap tied 0, trap_clr unused.
// TESTING
//  1 Reset: reset_n=0 mid-EXEC of ADD -> psr=0, rf_we never pulses, instr_ready=1 next cycle.
//  2 ADD R3,R4 (16'h0354), A=16'h7FFF B=16'h0001 -> alu_opcode 8'h05, cycle 3 rf_we=1
//    rf_waddr=3 rf_wdata=16'h8000, psr F=1 N=0 C=0.
//  3 CMPI R2,#5 (16'hB205), A=5 -> alu_opcode 8'hB0, b_sel=1, no rf_we, psr Z=1.
//  4 MOV R1,R2 (16'h01D2) after step 3 -> rf_we, psr still Z=1 (unchanged).
//  5 LOAD word 16'h4102 -> illegal pulse in cycle 1, no rf_we, instr_ready=1 in cycle 2;
//    with ILLEGAL_TRAP_EN: trap=1, instr_ready=0 until trap_clr.
//  6 Back-to-back: instr_valid held high with 3 words -> each accepted 4 cycles apart, in order.

Source files
------------

// File: rtl/cr16_decode_ctrl_if.sv
// Instruction fetch handshake between the fetch unit (master) and cr16_decode_ctrl (slave).
interface cr16_decode_ctrl_if;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready
   );
endinterface

// File: rtl/cr16_decode_ctrl.sv
// CR16 instruction decode / execute sequencer: IDLE->DECODE->EXEC->WB, drives RF and ALU, owns PSR.
// Optional macro ILLEGAL_TRAP_EN: illegal words raise a sticky trap that stalls fetch.
module cr16_decode_ctrl #(
   parameter int unsigned       DATA_W  = 16,
   parameter int unsigned       FLAG_W  = 5,
   parameter logic [FLAG_W-1:0] PSR_RST = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   cr16_decode_ctrl_if.slave   fetch,
   output logic [3:0]          rf_addr_a,
   output logic [3:0]          rf_addr_b,
   output logic                b_sel,
   output logic [DATA_W-1:0]   imm,
   output logic [7:0]          alu_opcode,
   input  logic [DATA_W-1:0]   alu_c,
   input  logic [FLAG_W-1:0]   alu_flags,
   output logic                rf_we,
   output logic [3:0]          rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   output logic [FLAG_W-1:0]   psr,
   output logic                illegal,
   output logic                trap,
   input  logic                trap_clr
);

   typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

   state_e              state_q, state_d;
   logic [15:0]         instr_q, instr_d;
   logic [DATA_W-1:0]   alu_c_q, alu_c_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [FLAG_W-1:0]   psr_q, psr_d;
   logic                trap_q, trap_d;

   logic [3:0] op, ext;
   logic       legal, b_sel_dec, psr_upd, wb_en, accept;

   assign op     = instr_q[15:12];
   assign ext    = instr_q[7:4];
   assign accept = fetch.instr_valid && fetch.instr_ready;

   // Decode of the latched word
   always_comb begin
      legal     = 1'b0;
      b_sel_dec = 1'b0;
      case (op)
         4'h0: legal = ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD};
         4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF: begin
            legal     = 1'b1;
            b_sel_dec = 1'b1;
         end
         4'h8: begin
            legal     = ext inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
            b_sel_dec = ~ext[2];
         end
         default: ;
      endcase
      psr_upd = legal && ((op inside {4'h1, 4'h5, 4'h9, 4'hB}) ||
                          ((op == 4'h0) && (ext inside {4'h1, 4'h5, 4'h9, 4'hB})));
      wb_en   = !((op == 4'hB) || ((op == 4'h0) && (ext == 4'hB)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StDecode;
         StDecode: state_d = legal ? StExec : StIdle;
         StExec:   state_d = StWb;
         StWb:     state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      fetch.instr_ready = (state_q == StIdle) && !trap_q;
      illegal           = (state_q == StDecode) && !legal;
      rf_we             = (state_q == StWb) && wb_en;
   end

   always_comb begin
      instr_d = accept ? fetch.instr : instr_q;
      alu_c_d = (state_q == StExec) ? alu_c : alu_c_q;
      flags_d = (state_q == StExec) ? alu_flags : flags_q;
      psr_d   = ((state_q == StWb) && psr_upd) ? flags_q : psr_q;
`ifdef ILLEGAL_TRAP_EN
      // A new illegal word wins over a simultaneous clear.
      if (illegal)       trap_d = 1'b1;
      else if (trap_clr) trap_d = 1'b0;
      else               trap_d = trap_q;
`else
      trap_d = 1'b0;
`endif
   end

`ifndef ILLEGAL_TRAP_EN
   logic unused_trap_clr;
   assign unused_trap_clr = trap_clr;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_q <= '0;
         alu_c_q <= '0;
         flags_q <= '0;
         psr_q   <= PSR_RST;
         trap_q  <= 1'b0;
      end else begin
         instr_q <= instr_d;
         alu_c_q <= alu_c_d;
         flags_q <= flags_d;
         psr_q   <= psr_d;
         trap_q  <= trap_d;
      end
   end

   assign rf_addr_a  = instr_q[11:8];
   assign rf_addr_b  = instr_q[3:0];
   assign b_sel      = b_sel_dec;
   assign imm        = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
   assign alu_opcode = {op, ext};
   assign rf_waddr   = instr_q[11:8];
   assign rf_wdata   = alu_c_q;
   assign psr        = psr_q;
   assign trap       = trap_q;

endmodule
